p_i_cache_ctrl_nway: RTL

- Parametrised controller for the pipelined instruction cache, replacing the fixed 4-way, single-beat controller.
- Supports any power-of-two way count with tree-PLRU replacement, multi-beat line fills over a narrow memory bus, and a set-walking invalidate-all flush.
- Sits between the fetch stage, the I-cache lookup pipeline register, and the physical-memory arbiter port.

---
 rtl/p_i_cache_ctrl_nway.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/p_i_cache_ctrl_nway.sv
// Instruction-cache controller: N-way tree-PLRU replacement, multi-beat line fills
// and a set-walking invalidate-all flush, between fetch, lookup stage and memory port.
module p_i_cache_ctrl_nway #(
  parameter int WAYS           = 4,
  parameter int SETS           = 16,
  parameter int LINE_BEATS     = 4,
  parameter int FLUSH_ON_RESET = 1,
  localparam int WW = $clog2(WAYS),
  localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1,
  localparam int SW = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  output logic            mem_resp,
  input  logic            lookup_valid,
  input  logic [WAYS-1:0] hit_vec,
  input  logic [WAYS-1:0] valid_vec,
  input  logic [WAYS-2:0] plru_in,
  input  logic            pipe_advance,
  input  logic            flush_req,
  output logic            pmem_read,
  input  logic            pmem_resp,
  output logic [WAYS-1:0] way_tag_load,
  output logic            valid_datain,
  output logic [WAYS-1:0] data_we,
  output logic [BW-1:0]   beat_idx,
  output logic            plru_load,
  output logic [WAYS-2:0] plru_datain,
  output logic [SW-1:0]   flush_set_idx,
  output logic            flush_busy,
  output logic            load_stage_reg,
  output logic            addr_sel
);

  typedef enum logic [1:0] {RUN, FILL, RESPOND, FLUSH} state_t;

  state_t         state_reg, state_next;
  logic [BW-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [SW-1:0]  set_cnt_reg, set_cnt_next;
  logic [WW-1:0]  victim_reg, victim_next;

  logic           hit;
  logic [WW-1:0]  hit_way;
  logic           inv_found;
  logic [WW-1:0]  inv_way;
  logic [WAYS-1:0] plru_ext;
  logic [WW:0]    plru_node;
  logic [WW-1:0]  plru_idx;
  logic [WW-1:0]  plru_way;
  logic [WW-1:0]  victim_sel;
  logic [WW:0]    hit_leaf;
  logic [WAYS-2:0] plru_upd;
  logic           last_beat;
  logic           last_set;

  assign hit = |hit_vec;

  // Scan high-to-low so the lowest set index wins.
  always_comb begin
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WW'(i);
      if (!valid_vec[i]) begin
        inv_found = 1'b1;
        inv_way   = WW'(i);
      end
    end
  end

  assign plru_ext = {1'b0, plru_in};

  always_comb begin
    plru_node = (WW+1)'(1);
    plru_idx  = '0;
    for (int d = 0; d < WW; d++) begin
      plru_idx  = WW'(plru_node - (WW+1)'(1));
      plru_node = {plru_node[WW-1:0], plru_ext[plru_idx]};
    end
    plru_way = WW'(plru_node - (WW+1)'(WAYS));
  end

  assign victim_sel = inv_found ? inv_way : plru_way;

  // Each node on the hit way's root-to-leaf path is turned to point at the other subtree.
  assign hit_leaf = {1'b1, hit_way};

  genvar gi;
  generate
    for (gi = 0; gi < WAYS - 1; gi++) begin : g_plru
      localparam int NODE  = gi + 1;
      localparam int DEPTH = $clog2(NODE + 1) - 1;
      assign plru_upd[gi] = ((hit_leaf >> (WW - DEPTH)) == (WW+1)'(NODE))
                            ? ~hit_leaf[WW-DEPTH-1] : plru_in[gi];
    end
  endgenerate

  assign last_beat = (beat_cnt_reg == BW'(LINE_BEATS - 1));
  assign last_set  = (set_cnt_reg == SW'(SETS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= (FLUSH_ON_RESET != 0) ? FLUSH : RUN;
      beat_cnt_reg <= '0;
      set_cnt_reg  <= '0;
      victim_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      set_cnt_reg  <= set_cnt_next;
      victim_reg   <= victim_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    beat_cnt_next  = beat_cnt_reg;
    set_cnt_next   = set_cnt_reg;
    victim_next    = victim_reg;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    way_tag_load   = '0;
    valid_datain   = 1'b0;
    data_we        = '0;
    beat_idx       = '0;
    plru_load      = 1'b0;
    plru_datain    = '0;
    flush_set_idx  = '0;
    flush_busy     = 1'b0;
    load_stage_reg = 1'b1;
    addr_sel       = 1'b0;

    case (state_reg)
      RUN: begin
        if (flush_req) begin
          load_stage_reg = 1'b0;
          state_next     = FLUSH;
        end else if (lookup_valid && mem_read) begin
          if (hit) begin
            if (pipe_advance) begin
              mem_resp    = 1'b1;
              plru_load   = 1'b1;
              plru_datain = plru_upd;
            end else begin
              load_stage_reg = 1'b0;
            end
          end else begin
            victim_next    = victim_sel;
            beat_cnt_next  = '0;
            load_stage_reg = 1'b0;
            addr_sel       = 1'b1;
            state_next     = FILL;
          end
        end
      end

      FILL: begin
        pmem_read      = 1'b1;
        addr_sel       = 1'b1;
        load_stage_reg = 1'b0;
        if (pmem_resp) begin
          data_we[victim_reg] = 1'b1;
          beat_idx            = beat_cnt_reg;
          beat_cnt_next       = beat_cnt_reg + 1'b1;
          if (last_beat) begin
            way_tag_load[victim_reg] = 1'b1;
            valid_datain             = 1'b1;
            state_next               = RESPOND;
          end
        end
      end

      // Re-present the held address so the freshly filled line is served as a hit.
      RESPOND: begin
        addr_sel       = 1'b1;
        load_stage_reg = 1'b1;
        state_next     = RUN;
      end

      FLUSH: begin
        way_tag_load   = '1;
        valid_datain   = 1'b0;
        plru_load      = 1'b1;
        plru_datain    = '0;
        flush_set_idx  = set_cnt_reg;
        flush_busy     = 1'b1;
        load_stage_reg = 1'b0;
        if (last_set) begin
          set_cnt_next = '0;
          state_next   = RUN;
        end else begin
          set_cnt_next = set_cnt_reg + 1'b1;
        end
      end

      default: state_next = RUN;
    endcase
  end

endmodule
